sync_fifo: RTL

Single-clock, parametrised ready/valid FIFO that uses all 2^ADDR_WIDTH entries, with occupancy count, programmable almost-full/almost-empty flags, a synchronous flush and a high-water-mark register. It is the same-clock-domain counterpart of our dual-clock FIFO. It is used for rate smoothing and elastic buffering between pipeline stages that share a clock, and designers can swap one for the other without changing handshake logic.

---
 rtl/sync_fifo.sv | 94 +++++++++
 1 files changed

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock ready/valid FIFO using all 2**ADDR_WIDTH entries,
//               with occupancy count, almost-full/empty flags, synchronous
//               flush and a high-water-mark register.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  output logic                  o_ready_in,
  input  logic                  i_valid_in,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_ready_out,
  output logic                  o_valid_out,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_max_count
);

  localparam int                DEPTH    = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] c_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] c_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] c_ZERO   = '0;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_max_count;

  logic                  w_clear;
  logic [ADDR_WIDTH:0]   w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH:0]   w_next_count;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  // Pointers carry one extra bit so that a full FIFO (count == DEPTH) is
  // distinguishable from an empty one without a separate flag register.
  assign w_clear   = i_reset | i_flush;
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == c_DEPTH);
  assign w_empty   = (w_count == c_ZERO);
  assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
  assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

  assign o_ready_in  = ~w_full  & ~w_clear;
  assign o_valid_out = ~w_empty & ~w_clear;

  assign w_push = i_valid_in  & o_ready_in;
  assign w_pop  = o_valid_out & i_ready_out;

  assign w_next_count = w_count + (w_push ? c_ONE : c_ZERO) - (w_pop ? c_ONE : c_ZERO);

  assign o_data_out     = r_mem[w_rd_addr];
  assign o_count        = w_count;
  assign o_almost_full  = (w_count >= c_AFULL);
  assign o_almost_empty = (w_count <= c_AEMPTY);
  assign o_max_count    = r_max_count;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_max_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
      // next count never exceeds DEPTH, so the mark saturates there by itself
      if (w_next_count > r_max_count) r_max_count <= w_next_count;
    end
  end

  // Storage is not cleared; stale words are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_addr] <= i_data_in;
  end

endmodule
`default_nettype wire
